// File: rtl/op1_scheduler.sv
// Round-robin front end that shares one operation1 datapath between NUM_REQ
// requesters, one command in flight, with a watchdog on the result handshake.
module op1_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int TAG_WIDTH = 5,
  parameter int TIMEOUT   = 1024,
  localparam int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*64-1:0]         req_rs1,
  input  logic [NUM_REQ*64-1:0]         req_rs2,
  input  logic [NUM_REQ*TAG_WIDTH-1:0]  req_rd,
  output logic [31:0]                   op_input_a,
  output logic [31:0]                   op_input_b,
  output logic [31:0]                   op_input_c,
  output logic [31:0]                   op_input_d,
  output logic                          op_input_stb,
  input  logic                          op_busy,
  input  logic [31:0]                   op_result,
  input  logic                          op_output_stb,
  output logic                          op_output_busy,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [ID_W-1:0]               resp_id,
  output logic [TAG_WIDTH-1:0]          resp_rd,
  output logic [31:0]                   resp_data,
  output logic                          resp_err,
  output logic                          sched_busy
);

  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                 state, state_nx;
  logic [ID_W-1:0]        ptr, grant;
  logic                   found;
  logic [TW-1:0]          timer;
  logic                   stale;
  logic                   in_xfer, out_xfer, timeout;

  logic [63:0]            rs1_arr [NUM_REQ];
  logic [63:0]            rs2_arr [NUM_REQ];
  logic [TAG_WIDTH-1:0]   rd_arr  [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign rs1_arr[i] = req_rs1[i*64 +: 64];
    assign rs2_arr[i] = req_rs2[i*64 +: 64];
    assign rd_arr[i]  = req_rd[i*TAG_WIDTH +: TAG_WIDTH];
  end

  // First valid requester at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        grant = ID_W'(idx);
        found = 1'b1;
      end
    end
  end

  // A late result after a timeout must be swallowed before the next issue.
  assign op_input_stb   = (state == ISSUE) && !stale;
  assign op_output_busy = !((state == WAIT) || stale);
  assign resp_valid     = (state == RESP);
  assign sched_busy     = (state != IDLE);
  assign req_ready      = (state == IDLE && found) ? (NUM_REQ'(1) << grant) : '0;

  assign in_xfer  = op_input_stb && !op_busy;
  assign out_xfer = op_output_stb && !op_output_busy;
  assign timeout  = (timer == TW'(TIMEOUT - 1));

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (found) state_nx = ISSUE;
      ISSUE:   if (in_xfer) state_nx = WAIT;
      WAIT:    if (out_xfer || timeout) state_nx = RESP;
      RESP:    if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      stale      <= 1'b0;
      timer      <= '0;
      op_input_a <= '0;
      op_input_b <= '0;
      op_input_c <= '0;
      op_input_d <= '0;
      resp_id    <= '0;
      resp_rd    <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && found) begin
        op_input_a <= rs1_arr[grant][63:32];
        op_input_b <= rs1_arr[grant][31:0];
        op_input_c <= rs2_arr[grant][63:32];
        op_input_d <= rs2_arr[grant][31:0];
        resp_rd    <= rd_arr[grant];
        resp_id    <= grant;
        ptr        <= ID_W'((int'(grant) + 1) % NUM_REQ);
      end
      if (in_xfer)
        timer <= '0;
      else if (state == WAIT && !out_xfer && !timeout)
        timer <= timer + 1'b1;
      // A result in the timeout cycle takes priority over the error.
      if (state == WAIT) begin
        if (out_xfer) begin
          resp_data <= op_result;
          resp_err  <= 1'b0;
        end else if (timeout) begin
          resp_data <= '0;
          resp_err  <= 1'b1;
          stale     <= 1'b1;
        end
      end else if (stale && out_xfer) begin
        stale <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_op1_scheduler.sv
// Directed bench for op1_scheduler: a vector table of full transactions plus
// hand-written backpressure, timeout, stale-discard and reset sequences.
module tb_op1_scheduler;

  localparam int NR = 4;
  localparam int TGW = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*64-1:0]  req_rs1, req_rs2;
  logic [NR*TGW-1:0] req_rd;
  logic [31:0]       op_input_a, op_input_b, op_input_c, op_input_d;
  logic              op_input_stb, op_busy;
  logic [31:0]       op_result;
  logic              op_output_stb, op_output_busy;
  logic              resp_valid, resp_ready;
  logic [1:0]        resp_id;
  logic [TGW-1:0]    resp_rd;
  logic [31:0]       resp_data;
  logic              resp_err, sched_busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  op1_scheduler #(.NUM_REQ(NR), .TAG_WIDTH(TGW), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
    .op_input_a(op_input_a), .op_input_b(op_input_b),
    .op_input_c(op_input_c), .op_input_d(op_input_d),
    .op_input_stb(op_input_stb), .op_busy(op_busy),
    .op_result(op_result), .op_output_stb(op_output_stb),
    .op_output_busy(op_output_busy),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_rd(resp_rd), .resp_data(resp_data),
    .resp_err(resp_err), .sched_busy(sched_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]     valid;
    int             exp_id;
    logic [63:0]    rs1;
    logic [63:0]    rs2;
    logic [TGW-1:0] rd;
    logic [31:0]    result;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // The expected requester gets the vector's data; the others get decoys.
  task automatic drive_reqs(input vec_t v);
    for (int i = 0; i < NR; i++) begin
      if (i == v.exp_id) begin
        req_rs1[i*64 +: 64] = v.rs1;
        req_rs2[i*64 +: 64] = v.rs2;
        req_rd[i*TGW +: TGW] = v.rd;
      end else begin
        req_rs1[i*64 +: 64] = {32'hEEEE0000 | i, 32'h55550000 | i};
        req_rs2[i*64 +: 64] = {32'h77770000 | i, 32'h99990000 | i};
        req_rd[i*TGW +: TGW] = TGW'(i + 16);
      end
    end
    req_valid = v.valid;
  endtask

  function automatic vec_t mk(input logic [3:0] va, input int id, input logic [63:0] r1,
                              input logic [63:0] r2, input logic [TGW-1:0] rd,
                              input logic [31:0] res);
    vec_t v;
    v.valid = va; v.exp_id = id; v.rs1 = r1; v.rs2 = r2; v.rd = rd; v.result = res;
    return v;
  endfunction

  // Called at a negedge with the DUT in IDLE; returns at a negedge+1 in IDLE.
  task automatic run_txn(input vec_t v);
    logic [3:0] g;
    g = 4'b0001 << v.exp_id;
    drive_reqs(v);
    #1;
    chk("idle_sched_busy", sched_busy, 0);
    chk("grant", req_ready, g);
    @(negedge clk); #1;
    chk("issue_stb", op_input_stb, 1);
    chk("issue_ready", req_ready, 0);
    chk("op_a", op_input_a, v.rs1[63:32]);
    chk("op_b", op_input_b, v.rs1[31:0]);
    chk("op_c", op_input_c, v.rs2[63:32]);
    chk("op_d", op_input_d, v.rs2[31:0]);
    @(negedge clk);
    op_output_stb = 1'b1; op_result = v.result; #1;
    chk("wait_stb", op_input_stb, 0);
    chk("wait_obusy", op_output_busy, 0);
    @(negedge clk);
    op_output_stb = 1'b0; #1;
    chk("resp_valid", resp_valid, 1);
    chk("resp_id", resp_id, v.exp_id);
    chk("resp_rd", resp_rd, v.rd);
    chk("resp_data", resp_data, v.result);
    chk("resp_err", resp_err, 0);
    chk("resp_obusy", op_output_busy, 1);
    @(negedge clk); #1;
    chk("back_idle", resp_valid, 0);
    req_valid = '0;
  endtask

  initial begin
    vec_t v;
    vecs[0] = mk(4'b1111, 0, 64'h11111111_22222222, 64'h33333333_44444444, 5'd1,  32'hA0000001);
    vecs[1] = mk(4'b1111, 1, 64'hFFFFFFFF_00000000, 64'h00000000_FFFFFFFF, 5'd31, 32'h00000000);
    vecs[2] = mk(4'b1111, 2, 64'h01234567_89ABCDEF, 64'hFEDCBA98_76543210, 5'd2,  32'h22222222);
    vecs[3] = mk(4'b1111, 3, 64'hA5A5A5A5_5A5A5A5A, 64'h0F0F0F0F_F0F0F0F0, 5'd3,  32'h33333333);
    vecs[4] = mk(4'b1111, 0, 64'h00000010_00000020, 64'h00000030_00000040, 5'd4,  32'h44444444);
    vecs[5] = mk(4'b0100, 2, 64'h00000001_00000002, 64'h00000003_00000004, 5'd7,  32'hDEADBEEF);
    vecs[6] = mk(4'b0011, 0, 64'hCAFEBABE_00000001, 64'h00000002_CAFEBABE, 5'd10, 32'h66666666);
    vecs[7] = mk(4'b1001, 3, 64'h80000000_00000001, 64'h7FFFFFFF_FFFFFFFE, 5'd11, 32'h77777777);
    vecs[8] = mk(4'b0010, 1, 64'h0000ABCD_0000DCBA, 64'h12340000_43210000, 5'd0,  32'h88888888);

    rst = 1'b1; req_valid = '0; req_rs1 = '0; req_rs2 = '0; req_rd = '0;
    op_busy = 1'b0; op_result = '0; op_output_stb = 1'b0; resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0; #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_stb", op_input_stb, 0);
    chk("rst_obusy", op_output_busy, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_id", resp_id, 0);
    chk("rst_resp_rd", resp_rd, 0);
    chk("rst_op_a", op_input_a, 0);
    chk("rst_op_d", op_input_d, 0);
    chk("rst_sched_busy", sched_busy, 0);
    @(negedge clk);

    // Fairness (0,1,2,3,0) then skipping of idle requesters.
    foreach (vecs[i]) run_txn(vecs[i]);

    // Operand backpressure and response backpressure; ptr is 2 here.
    @(negedge clk);
    v = mk(4'b0010, 1, 64'h10203040_50607080, 64'h90A0B0C0_D0E0F000, 5'd5, 32'h13579BDF);
    drive_reqs(v); op_busy = 1'b1; #1;
    chk("bp_grant", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = '0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk("bp_stb_held", op_input_stb, 1);
      chk("bp_op_a", op_input_a, 32'h10203040);
      chk("bp_op_d", op_input_d, 32'hD0E0F000);
    end
    @(negedge clk);
    op_busy = 1'b0; #1;
    chk("bp_stb_release", op_input_stb, 1);
    @(negedge clk); #1;
    chk("bp_wait_stb", op_input_stb, 0);
    chk("bp_wait_busy", sched_busy, 1);
    @(negedge clk);
    op_output_stb = 1'b1; op_result = 32'h13579BDF;
    @(negedge clk);
    op_output_stb = 1'b0; resp_ready = 1'b0; req_valid = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk("rbp_valid", resp_valid, 1);
      chk("rbp_data", resp_data, 32'h13579BDF);
      chk("rbp_id", resp_id, 1);
      chk("rbp_no_accept", req_ready, 0);
    end
    @(negedge clk);
    resp_ready = 1'b1; #1;
    chk("rbp_still_valid", resp_valid, 1);
    @(negedge clk); #1;
    chk("rbp_idle", resp_valid, 0);
    chk("rbp_next_grant", req_ready, 4'b0100);
    req_valid = '0;

    // Watchdog: no result for 8 WAIT cycles.
    @(negedge clk);
    v = mk(4'b1000, 3, 64'h0BAD0BAD_0BAD0BAD, 64'h0, 5'd9, 32'h0);
    drive_reqs(v); #1;
    chk("to_grant", req_ready, 4'b1000);
    @(negedge clk);
    req_valid = '0; #1;
    chk("to_stb", op_input_stb, 1);
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk("to_waiting", resp_valid, 0);
    end
    @(negedge clk); #1;
    chk("to_valid", resp_valid, 1);
    chk("to_err", resp_err, 1);
    chk("to_data", resp_data, 0);
    chk("to_id", resp_id, 3);
    chk("to_rd", resp_rd, 9);
    chk("to_stale_obusy", op_output_busy, 0);

    // Next command stalls in ISSUE until the late result is swallowed.
    @(negedge clk);
    v = mk(4'b0001, 0, 64'h00000005_00000006, 64'h00000007_00000008, 5'd14, 32'hCAFEF00D);
    drive_reqs(v); #1;
    chk("st_grant", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk("st_stb_blocked", op_input_stb, 0);
      chk("st_obusy", op_output_busy, 0);
    end
    @(negedge clk);
    op_output_stb = 1'b1; op_result = 32'h12345678; #1;
    chk("st_stb_late", op_input_stb, 0);
    @(negedge clk);
    op_output_stb = 1'b0; #1;
    chk("st_stb_go", op_input_stb, 1);
    chk("st_obusy_clr", op_output_busy, 1);
    chk("st_op_a", op_input_a, 32'h00000005);
    @(negedge clk);
    op_output_stb = 1'b1; op_result = 32'hCAFEF00D;
    @(negedge clk);
    op_output_stb = 1'b0; #1;
    chk("st_data", resp_data, 32'hCAFEF00D);
    chk("st_err", resp_err, 0);
    chk("st_id", resp_id, 0);

    // Result lands in the timeout cycle itself.
    @(negedge clk);
    v = mk(4'b0010, 1, 64'h1, 64'h2, 5'd12, 32'h600DF00D);
    drive_reqs(v); #1;
    chk("edge_grant", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    for (int k = 0; k < 7; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk("edge_waiting", resp_valid, 0);
    end
    @(negedge clk);
    op_output_stb = 1'b1; op_result = 32'h600DF00D;
    @(negedge clk);
    op_output_stb = 1'b0; #1;
    chk("edge_valid", resp_valid, 1);
    chk("edge_err", resp_err, 0);
    chk("edge_data", resp_data, 32'h600DF00D);
    chk("edge_not_stale", op_output_busy, 1);

    // Reset during WAIT; ptr was 3 before reset.
    @(negedge clk);
    v = mk(4'b0100, 2, 64'h3, 64'h4, 5'd6, 32'h0);
    drive_reqs(v); #1;
    chk("mr_grant", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk); #1;
    chk("mr_wait_busy", sched_busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; #1;
    chk("mr_sched_busy", sched_busy, 0);
    chk("mr_resp_valid", resp_valid, 0);
    chk("mr_stb", op_input_stb, 0);
    chk("mr_obusy", op_output_busy, 1);
    chk("mr_resp_data", resp_data, 0);
    chk("mr_resp_id", resp_id, 0);
    chk("mr_resp_rd", resp_rd, 0);
    chk("mr_op_a", op_input_a, 0);
    @(negedge clk); #1;
    chk("mr_no_resp", resp_valid, 0);
    @(negedge clk);
    run_txn(mk(4'b1111, 0, 64'hAAAA5555_5555AAAA, 64'h1234_5678_9ABC_DEF0, 5'd21, 32'hF00DFACE));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
